eth_rx_flow_monitor: RTL and testbench



---
 rtl/eth_rx_flow_monitor_if.sv | 61 ++++++
 rtl/eth_rx_flow_monitor.sv | 215 +++++++++++++++++++++
 tb/tb_eth_rx_flow_monitor.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_flow_monitor_if.sv
// Bundles the RX AXI-Stream sink and AXI-Lite register port of the flow monitor.
interface eth_rx_flow_monitor_if #(
    parameter int AXIL_ADDR_WIDTH = 32
);
    logic [63:0]                s_axis_tdata;
    logic [7:0]                 s_axis_tkeep;
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic                       s_axis_tlast;
    logic                       s_axis_tuser;

    logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr;
    logic [2:0]                 s_axil_awprot;
    logic                       s_axil_awvalid;
    logic                       s_axil_awready;
    logic [31:0]                s_axil_wdata;
    logic [3:0]                 s_axil_wstrb;
    logic                       s_axil_wvalid;
    logic                       s_axil_wready;
    logic [1:0]                 s_axil_bresp;
    logic                       s_axil_bvalid;
    logic                       s_axil_bready;
    logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr;
    logic [2:0]                 s_axil_arprot;
    logic                       s_axil_arvalid;
    logic                       s_axil_arready;
    logic [31:0]                s_axil_rdata;
    logic [1:0]                 s_axil_rresp;
    logic                       s_axil_rvalid;
    logic                       s_axil_rready;

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        input  s_axil_awready,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_wready,
        input  s_axil_bresp, s_axil_bvalid,
        output s_axil_bready,
        output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
        input  s_axil_arready,
        input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output s_axil_rready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        output s_axil_awready,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_wready,
        output s_axil_bresp, s_axil_bvalid,
        input  s_axil_bready,
        input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
        output s_axil_arready,
        output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  s_axil_rready
    );
endinterface

// File: rtl/eth_rx_flow_monitor.sv
// Classifies received UDP frames by destination port into per-flow packet/byte
// counters with global error counters, all readable over AXI-Lite.
module eth_rx_flow_monitor #(
    parameter int          N_FLOWS           = 2,
    parameter int          AXIL_ADDR_WIDTH   = 32,
    parameter logic [15:0] DEFAULT_PORT_BASE = 16'd5000
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_rx_flow_monitor_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) c = c + {3'd0, k[i]};
        return c;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [AXIL_ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [5:0]  aw_word, ar_word;

    state_t      state;
    logic [2:0]  beat_cnt;
    logic [15:0] frame_len, port;
    logic        port_ok;

    logic        commit_valid, commit_bad, commit_port_ok;
    logic [15:0] commit_port, commit_len, commit_idx;

    logic [3:0]  beat_bytes;
    logic [15:0] beat_len, beat_port;
    logic        beat_port_ok, hit_port, beat_counted;

    logic        enable;
    logic [15:0] port_base;
    logic [31:0] cnt_total, cnt_bad, cnt_runt, cnt_unmatched;
    logic [31:0] flow_pkts  [N_FLOWS];
    logic [31:0] flow_bytes [N_FLOWS];
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign aw_addr = bus.s_axil_awaddr;
    assign ar_addr = bus.s_axil_araddr;
    assign aw_word = aw_addr[7:2];
    assign ar_word = ar_addr[7:2];

    assign bus.s_axis_tready = 1'b1;
    assign bus.s_axil_bresp  = 2'b00;
    assign bus.s_axil_rresp  = 2'b00;

    assign unused_bits = ^{aw_addr, ar_addr, bus.s_axil_awprot, bus.s_axil_arprot,
                           bus.s_axil_wstrb, bus.s_axil_wdata, bus.s_axis_tdata};

    // Values this beat would leave behind, so a tlast on any beat (including
    // beat 4 itself) commits with a consistent length and port.
    always_comb begin
        beat_bytes   = popcount8(bus.s_axis_tkeep);
        hit_port     = (state == HDR) && (beat_cnt == 3'd4);
        beat_len     = (state == IDLE) ? {12'd0, beat_bytes} : sat_add(frame_len, beat_bytes);
        beat_port    = hit_port ? {bus.s_axis_tdata[39:32], bus.s_axis_tdata[47:40]} : port;
        beat_port_ok = (state != IDLE) && (port_ok || hit_port);
        beat_counted = (state == IDLE) ? enable : (state != DROP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            frame_len      <= '0;
            port           <= '0;
            port_ok        <= 1'b0;
            commit_valid   <= 1'b0;
            commit_bad     <= 1'b0;
            commit_port_ok <= 1'b0;
            commit_port    <= '0;
            commit_len     <= '0;
        end else begin
            commit_valid <= 1'b0;
            if (bus.s_axis_tvalid) begin
                frame_len <= beat_len;
                port      <= beat_port;
                port_ok   <= beat_port_ok;
                if (bus.s_axis_tlast) begin
                    state          <= IDLE;
                    commit_valid   <= beat_counted;
                    commit_bad     <= bus.s_axis_tuser;
                    commit_port_ok <= beat_port_ok;
                    commit_port    <= beat_port;
                    commit_len     <= beat_len;
                end else begin
                    unique case (state)
                        IDLE: begin
                            beat_cnt <= 3'd1;
                            state    <= enable ? HDR : DROP;
                        end
                        HDR: begin
                            if (hit_port) state <= PAYLOAD;
                            else          beat_cnt <= beat_cnt + 3'd1;
                        end
                        PAYLOAD, DROP: ;
                    endcase
                end
            end
        end
    end

    assign commit_idx = commit_port - port_base;

    always_comb begin
        rd_mux = '0;
        unique case (ar_word)
            6'd0: rd_mux = 32'h464D4F4E;
            6'd1: rd_mux = {31'd0, enable};
            6'd2: rd_mux = {16'd0, port_base};
            6'd3: rd_mux = cnt_total;
            6'd4: rd_mux = cnt_bad;
            6'd5: rd_mux = cnt_runt;
            6'd6: rd_mux = cnt_unmatched;
            default: begin
                for (int unsigned i = 0; i < N_FLOWS; i++) begin
                    if (ar_word == 6'(8 + 2 * i)) rd_mux = flow_pkts[i];
                    if (ar_word == 6'(9 + 2 * i)) rd_mux = flow_bytes[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s_axil_awready <= 1'b0;
            bus.s_axil_wready  <= 1'b0;
            bus.s_axil_bvalid  <= 1'b0;
            bus.s_axil_arready <= 1'b0;
            bus.s_axil_rvalid  <= 1'b0;
            bus.s_axil_rdata   <= '0;
            enable             <= 1'b1;
            port_base          <= DEFAULT_PORT_BASE;
            cnt_total          <= '0;
            cnt_bad            <= '0;
            cnt_runt           <= '0;
            cnt_unmatched      <= '0;
            for (int unsigned i = 0; i < N_FLOWS; i++) begin
                flow_pkts[i]  <= '0;
                flow_bytes[i] <= '0;
            end
        end else begin
            bus.s_axil_awready <= 1'b0;
            bus.s_axil_wready  <= 1'b0;
            bus.s_axil_arready <= 1'b0;

            if (commit_valid) begin
                cnt_total <= cnt_total + 32'd1;
                if (commit_bad) begin
                    cnt_bad <= cnt_bad + 32'd1;
                end else if (!commit_port_ok) begin
                    cnt_runt <= cnt_runt + 32'd1;
                end else if (commit_idx < 16'(N_FLOWS)) begin
                    for (int unsigned i = 0; i < N_FLOWS; i++) begin
                        if (commit_idx == 16'(i)) begin
                            flow_pkts[i]  <= flow_pkts[i] + 32'd1;
                            flow_bytes[i] <= flow_bytes[i] + {16'd0, commit_len};
                        end
                    end
                end else begin
                    cnt_unmatched <= cnt_unmatched + 32'd1;
                end
            end

            if (bus.s_axil_bvalid && bus.s_axil_bready) bus.s_axil_bvalid <= 1'b0;
            if (bus.s_axil_awvalid && bus.s_axil_wvalid && !bus.s_axil_bvalid && !bus.s_axil_awready) begin
                bus.s_axil_awready <= 1'b1;
                bus.s_axil_wready  <= 1'b1;
            end
            // Decode happens at the end of the handshake cycle; a clear placed
            // after the commit update overrides any coincident increment.
            if (bus.s_axil_awready) begin
                bus.s_axil_bvalid <= 1'b1;
                if (aw_word == 6'd1) begin
                    enable <= bus.s_axil_wdata[0];
                    if (bus.s_axil_wdata[1]) begin
                        cnt_total     <= '0;
                        cnt_bad       <= '0;
                        cnt_runt      <= '0;
                        cnt_unmatched <= '0;
                        for (int unsigned i = 0; i < N_FLOWS; i++) begin
                            flow_pkts[i]  <= '0;
                            flow_bytes[i] <= '0;
                        end
                    end
                end else if (aw_word == 6'd2) begin
                    port_base <= bus.s_axil_wdata[15:0];
                end
            end

            if (bus.s_axil_rvalid && bus.s_axil_rready) bus.s_axil_rvalid <= 1'b0;
            if (bus.s_axil_arvalid && !bus.s_axil_rvalid && !bus.s_axil_arready) begin
                bus.s_axil_arready <= 1'b1;
            end
            if (bus.s_axil_arready) begin
                bus.s_axil_rvalid <= 1'b1;
                bus.s_axil_rdata  <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_flow_monitor.sv
// Self-checking bench for eth_rx_flow_monitor: frame table plus AXI-Lite
// register reads scored against a reference counter model.
module tb_eth_rx_flow_monitor;

    localparam int K_FLOW0 = 0, K_FLOW1 = 1, K_UNM = 2, K_RUNT = 3, K_BAD = 4;
    localparam int NV = 10;

    typedef struct {
        string       name;
        int          beats;
        logic [7:0]  last_keep;
        logic [15:0] port;
        bit          bad;
        int          kind;
        int          len;
        int          gap;
        bit          chk;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_total, m_bad, m_runt, m_unm;
    logic [31:0] m_pkts [2];
    logic [31:0] m_bytes [2];
    sb_t         sb_q [$];
    vec_t        vecs [NV];

    eth_rx_flow_monitor_if #(.AXIL_ADDR_WIDTH(32)) bus ();

    eth_rx_flow_monitor #(
        .N_FLOWS(2),
        .AXIL_ADDR_WIDTH(32),
        .DEFAULT_PORT_BASE(16'd5000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected DUT response", name);
    endtask

    task automatic send_frame(input int beats, input logic [7:0] last_keep,
                              input logic [15:0] port, input bit bad);
        logic [63:0] d;
        for (int b = 0; b < beats; b++) begin
            d = {$urandom, $urandom};
            if (b == 4) begin
                d[39:32] = port[15:8];
                d[47:40] = port[7:0];
            end
            bus.s_axis_tdata  = d;
            bus.s_axis_tkeep  = (b == beats - 1) ? last_keep : 8'hFF;
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (b == beats - 1);
            bus.s_axis_tuser  = (b == beats - 1) ? bad : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        bus.s_axil_awaddr  = addr;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wdata   = data;
        bus.s_axil_wstrb   = 4'hF;
        bus.s_axil_wvalid  = 1'b1;
        bus.s_axil_bready  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_axil_awready && n < 20);
        if (!bus.s_axil_awready) begin
            timeout_fail("awready");
            bus.s_axil_awvalid = 1'b0;
            bus.s_axil_wvalid  = 1'b0;
        end else begin
            @(negedge clk);
            bus.s_axil_awvalid = 1'b0;
            bus.s_axil_wvalid  = 1'b0;
            n = 0;
            while (!bus.s_axil_bvalid && n < 20) begin @(negedge clk); n++; end
            if (!bus.s_axil_bvalid) timeout_fail("bvalid");
            else check("bresp", {30'd0, bus.s_axil_bresp}, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic axil_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        int  n;
        sb_t e;
        bus.s_axil_araddr  = addr;
        bus.s_axil_arvalid = 1'b1;
        bus.s_axil_rready  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_axil_arready && n < 20);
        if (!bus.s_axil_arready) begin
            timeout_fail({name, "_arready"});
            bus.s_axil_arvalid = 1'b0;
        end else begin
            e.name = name;
            e.exp  = exp;
            sb_q.push_back(e);
            @(negedge clk);
            bus.s_axil_arvalid = 1'b0;
            n = 0;
            while (!bus.s_axil_rvalid && n < 20) begin @(negedge clk); n++; end
            e = sb_q.pop_front();
            if (!bus.s_axil_rvalid) timeout_fail({e.name, "_rvalid"});
            else check(e.name, bus.s_axil_rdata, e.exp);
            @(negedge clk);
        end
    endtask

    task automatic exp_commit(input int kind, input int len);
        m_total++;
        case (kind)
            K_FLOW0: begin m_pkts[0]++; m_bytes[0] += 32'(len); end
            K_FLOW1: begin m_pkts[1]++; m_bytes[1] += 32'(len); end
            K_UNM:   m_unm++;
            K_RUNT:  m_runt++;
            default: m_bad++;
        endcase
    endtask

    task automatic model_clear();
        m_total = '0; m_bad = '0; m_runt = '0; m_unm = '0;
        for (int i = 0; i < 2; i++) begin m_pkts[i] = '0; m_bytes[i] = '0; end
    endtask

    task automatic check_all(input string tag);
        repeat (2) @(negedge clk);
        axil_read(32'h0C, m_total, {tag, "_TOTAL"});
        axil_read(32'h10, m_bad,   {tag, "_BAD"});
        axil_read(32'h14, m_runt,  {tag, "_RUNT"});
        axil_read(32'h18, m_unm,   {tag, "_UNMATCHED"});
        axil_read(32'h20, m_pkts[0],  {tag, "_FLOW0_PKTS"});
        axil_read(32'h24, m_bytes[0], {tag, "_FLOW0_BYTES"});
        axil_read(32'h28, m_pkts[1],  {tag, "_FLOW1_PKTS"});
        axil_read(32'h2C, m_bytes[1], {tag, "_FLOW1_BYTES"});
    endtask

    initial begin
        vecs[0] = '{"f64_p5000",   8,    8'hFF, 16'd5000, 1'b0, K_FLOW0, 64, 2, 1'b1};
        vecs[1] = '{"f60_p5001_a", 8,    8'h0F, 16'd5001, 1'b0, K_FLOW1, 60, 0, 1'b0};
        vecs[2] = '{"f60_p5001_b", 8,    8'h0F, 16'd5001, 1'b0, K_FLOW1, 60, 0, 1'b0};
        vecs[3] = '{"f60_p5001_c", 8,    8'h0F, 16'd5001, 1'b0, K_FLOW1, 60, 2, 1'b1};
        vecs[4] = '{"unmatched",   8,    8'hFF, 16'd5007, 1'b0, K_UNM,   64, 2, 1'b0};
        vecs[5] = '{"runt3",       3,    8'hFF, 16'd5000, 1'b0, K_RUNT,  24, 2, 1'b0};
        vecs[6] = '{"bad8",        8,    8'hFF, 16'd5000, 1'b1, K_BAD,   64, 2, 1'b1};
        vecs[7] = '{"runt1",       1,    8'h01, 16'd5000, 1'b0, K_RUNT,   1, 0, 1'b0};
        vecs[8] = '{"last_on_b4",  5,    8'h03, 16'd5000, 1'b0, K_FLOW0, 34, 0, 1'b0};
        vecs[9] = '{"runt4",       4,    8'hFF, 16'd5001, 1'b0, K_RUNT,  32, 2, 1'b1};

        model_clear();
        bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0;
        bus.s_axil_awaddr = '0; bus.s_axil_awprot = '0; bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata = '0; bus.s_axil_wstrb = '0; bus.s_axil_wvalid = 1'b0;
        bus.s_axil_bready = 1'b0; bus.s_axil_araddr = '0; bus.s_axil_arprot = '0;
        bus.s_axil_arvalid = 1'b0; bus.s_axil_rready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_awready", {31'd0, bus.s_axil_awready}, 32'd0);
        check("rst_wready",  {31'd0, bus.s_axil_wready},  32'd0);
        check("rst_bvalid",  {31'd0, bus.s_axil_bvalid},  32'd0);
        check("rst_arready", {31'd0, bus.s_axil_arready}, 32'd0);
        check("rst_rvalid",  {31'd0, bus.s_axil_rvalid},  32'd0);
        check("rst_rdata",   bus.s_axil_rdata, 32'd0);
        check("tready",      {31'd0, bus.s_axis_tready},  32'd1);
        rst = 1'b0;
        @(negedge clk);

        axil_read(32'h00, 32'h464D4F4E, "rst_ID");
        axil_read(32'h04, 32'd1,        "rst_CTRL");
        axil_read(32'h08, 32'd5000,     "rst_PORT_BASE");
        check_all("rst");

        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].beats, vecs[i].last_keep, vecs[i].port, vecs[i].bad);
            exp_commit(vecs[i].kind, vecs[i].len);
            repeat (vecs[i].gap) @(negedge clk);
            if (vecs[i].chk) check_all(vecs[i].name);
        end

        axil_write(32'h0C, 32'hFFFF_FFFF);
        axil_read(32'h0C, m_total, "ro_TOTAL");
        axil_read(32'h1C, 32'd0, "gap_1C");
        axil_read(32'h30, 32'd0, "flow2_absent");
        axil_read(32'hFC, 32'd0, "unmapped_FC");

        send_frame(8200, 8'hFF, 16'd5000, 1'b0);
        exp_commit(K_FLOW0, 65535);
        check_all("saturate");

        axil_write(32'h04, 32'd0);
        axil_read(32'h04, 32'd0, "ctrl_off");
        send_frame(8, 8'hFF, 16'd5000, 1'b0);
        send_frame(3, 8'hFF, 16'd5001, 1'b0);
        check_all("disabled");
        axil_write(32'h04, 32'd1);
        send_frame(8, 8'h0F, 16'd5001, 1'b0);
        exp_commit(K_FLOW1, 60);
        check_all("reenabled");

        fork
            send_frame(8, 8'hFF, 16'd5000, 1'b0);
            begin
                @(negedge clk);
                axil_write(32'h04, 32'd0);
            end
        join
        exp_commit(K_FLOW0, 64);
        axil_write(32'h04, 32'd1);
        check_all("midframe_off");

        axil_write(32'h08, 32'h0000_1000);
        axil_read(32'h08, 32'h0000_1000, "PORT_BASE");
        send_frame(8, 8'hFF, 16'h1001, 1'b0);
        exp_commit(K_FLOW1, 64);
        send_frame(6, 8'h7F, 16'h0FFF, 1'b0);
        exp_commit(K_UNM, 47);
        send_frame(6, 8'h80, 16'h1000, 1'b0);
        exp_commit(K_FLOW0, 41);
        check_all("base1000");

        // CTRL write lands on the commit edge of the 8-beat frame.
        fork
            send_frame(8, 8'hFF, 16'h1001, 1'b0);
            begin
                repeat (7) @(negedge clk);
                axil_write(32'h04, 32'd3);
            end
        join
        model_clear();
        axil_read(32'h04, 32'd1, "clr_CTRL");
        check_all("clear");
        send_frame(8, 8'hFF, 16'h1000, 1'b0);
        exp_commit(K_FLOW0, 64);
        check_all("post_clear");

        begin
            int  n;
            sb_t e;
            bus.s_axil_araddr  = 32'h0C;
            bus.s_axil_arvalid = 1'b1;
            bus.s_axil_rready  = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.s_axil_arready && n < 20);
            if (!bus.s_axil_arready) begin
                timeout_fail("stall_arready");
            end else begin
                e.name = "stall_rdata";
                e.exp  = m_total;
                sb_q.push_back(e);
                @(negedge clk);
                e = sb_q.pop_front();
                for (int c = 0; c < 5; c++) begin
                    check("stall_rvalid",  {31'd0, bus.s_axil_rvalid},  32'd1);
                    check(e.name,          bus.s_axil_rdata,            e.exp);
                    check("stall_arready", {31'd0, bus.s_axil_arready}, 32'd0);
                    @(negedge clk);
                end
            end
            bus.s_axil_arvalid = 1'b0;
            bus.s_axil_rready  = 1'b1;
            @(negedge clk);
            check("stall_release", {31'd0, bus.s_axil_rvalid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
